// File: rtl/demux1c2_buf.sv
// 1-to-2 valid/ready demultiplexer with an independent FIFO per output.
// A stalled consumer only backs up the words that select its own side.

module demux1c2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_req,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic [CW-1:0]               cnt;
  logic                        pop;

  assign valid = (cnt != '0);
  assign full  = (cnt == CW'(DEPTH));
  assign rdata = mem[rptr];
  assign count = cnt;
  // A ready with nothing stored is ignored, so the read side never underflows.
  assign pop   = pop_req & valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (pop)
        rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

module demux1c2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             a_valid,
  output logic [WIDTH-1:0] a_data,
  input  logic             a_ready,
  output logic [CW-1:0]    a_count,
  output logic             b_valid,
  output logic [WIDTH-1:0] b_data,
  input  logic             b_ready,
  output logic [CW-1:0]    b_count
);

  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]            push, pop_req, valid, full;
  logic [NUM_LANES-1:0][WIDTH-1:0] rdata;
  logic [NUM_LANES-1:0][CW-1:0]    count;

  // Full blocks the push even if that side pops this edge: no push-through.
  assign in_ready = ~full[in_sel];
  assign pop_req  = {b_ready, a_ready};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign push[l] = in_valid & in_ready & (in_sel == 1'(l));

    demux1c2_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push[l]),
      .wdata   (in_data),
      .pop_req (pop_req[l]),
      .valid   (valid[l]),
      .rdata   (rdata[l]),
      .count   (count[l]),
      .full    (full[l])
    );
  end

  assign a_valid = valid[0];
  assign a_data  = rdata[0];
  assign a_count = count[0];
  assign b_valid = valid[1];
  assign b_data  = rdata[1];
  assign b_count = count[1];

endmodule

// File: tb/tb_demux1c2_buf.sv
// Random and directed bench for demux1c2_buf against a queue-based model of
// the two output FIFOs.

module tb_demux1c2_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_sel, in_ready;
  logic [WIDTH-1:0] in_data;
  logic             a_valid, a_ready, b_valid, b_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic [CW-1:0]    a_count, b_count;

  int nchk = 0;
  int nerr = 0;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];

  always #5 clk = ~clk;

  demux1c2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .in_ready (in_ready),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .a_count  (a_count),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .b_count  (b_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock period: drive at negedge, compare against the model, then let
  // the model take the edge exactly as the rules say it should.
  task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                      input logic ar, input logic br, output logic rdy);
    int   na, nb;
    logic acc, pa, pb;
    @(negedge clk);
    in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    #1;
    na = qa.size();
    nb = qb.size();
    chk("a_valid", 64'(a_valid), 64'(na != 0));
    chk("b_valid", 64'(b_valid), 64'(nb != 0));
    chk("a_count", 64'(a_count), 64'(na));
    chk("b_count", 64'(b_count), 64'(nb));
    chk("in_ready", 64'(in_ready), 64'(((s ? nb : na) != DEPTH)));
    if (na != 0) chk("a_data", 64'(a_data), 64'(qa[0]));
    if (nb != 0) chk("b_data", 64'(b_data), 64'(qb[0]));
    rdy = in_ready;
    acc = v && ((s ? nb : na) != DEPTH);
    pa  = ar && (na != 0);
    pb  = br && (nb != 0);
    @(posedge clk);
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (acc) begin
      if (s) qb.push_back(d);
      else   qa.push_back(d);
    end
  endtask

  initial begin
    logic rdy;
    logic pend_v, pend_s;
    logic [WIDTH-1:0] pend_d;
    logic v, s, ar, br;
    logic [WIDTH-1:0] d;

    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0;
    #12;
    chk("rst_a_valid", 64'(a_valid), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_a_count", 64'(a_count), 64'd0);
    chk("rst_b_data",  64'(b_data),  64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Routing and one-cycle latency
    step(1'b1, 1'b0, 32'h11111111, 1'b1, 1'b1, rdy);
    #1;
    chk("route_a_valid", 64'(a_valid), 64'd1);
    chk("route_a_data",  64'(a_data),  64'h11111111);
    chk("route_b_valid", 64'(b_valid), 64'd0);
    step(1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, rdy);
    #1;
    chk("route_b_data",  64'(b_data),  64'h22222222);
    chk("route_a_empty", 64'(a_count), 64'd0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, rdy);
    #1;
    chk("route_b_empty", 64'(b_count), 64'd0);

    // Full A does not block B
    step(1'b1, 1'b0, 32'hA0, 1'b0, 1'b0, rdy);
    step(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0, rdy);
    #1;
    chk("full_a_count", 64'(a_count), 64'd2);
    step(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0, rdy);
    chk("full_a_blocked", 64'(rdy), 64'd0);
    step(1'b1, 1'b1, 32'hB0, 1'b0, 1'b0, rdy);
    chk("full_b_accepted", 64'(rdy), 64'd1);
    #1;
    chk("full_b_count", 64'(b_count), 64'd1);

    // Full plus pop: pop only, then the held push goes in
    step(1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, rdy);
    chk("nopt_ready", 64'(rdy), 64'd0);
    #1;
    chk("nopt_count", 64'(a_count), 64'd1);
    chk("nopt_head",  64'(a_data),  64'hA1);
    step(1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, rdy);
    chk("nopt_retry", 64'(rdy), 64'd1);
    #1;
    chk("nopt_head2", 64'(a_data), 64'hA2);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, rdy);
    #1;
    chk("drain_a", 64'(a_count), 64'd0);
    chk("drain_b", 64'(b_count), 64'd0);

    // Streaming with pointer wrap
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b0, rdy);
      #1;
      chk("stream_count", 64'(a_count), 64'd1);
      chk("stream_data",  64'(a_data),  64'(i));
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, rdy);

    // Asynchronous reset in the middle of a period with A holding two words
    step(1'b1, 1'b0, 32'hC0, 1'b0, 1'b0, rdy);
    step(1'b1, 1'b0, 32'hC1, 1'b0, 1'b0, rdy);
    #1;
    chk("prerst_count", 64'(a_count), 64'd2);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_a_valid", 64'(a_valid), 64'd0);
    chk("arst_a_count", 64'(a_count), 64'd0);
    chk("arst_a_data",  64'(a_data),  64'd0);
    in_sel = 1'b0;
    #1;
    chk("arst_ready_a", 64'(in_ready), 64'd1);
    in_sel = 1'b1;
    #1;
    chk("arst_ready_b", 64'(in_ready), 64'd1);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst = 1'b0;

    // Random regression; a refused word is held until it is taken
    pend_v = 1'b0; pend_s = 1'b0; pend_d = '0;
    for (int c = 0; c < 10000; c++) begin
      if (pend_v) begin
        v = 1'b1; s = pend_s; d = pend_d;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = 1'($urandom_range(0, 1));
        d = $urandom;
      end
      ar = ($urandom_range(0, 2) != 0);
      br = ($urandom_range(0, 3) == 0);
      step(v, s, d, ar, br, rdy);
      pend_v = v && !rdy;
      pend_s = s;
      pend_d = d;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/demux1c2_buf.md
Name: demux1c2_buf

Overview:
Sequential 1-to-2 demultiplexer: the distributing counterpart of the team's 2:1 select mux. Routes one valid/ready input stream to output port A or B according to a per-word select bit. Each output has its own small FIFO, so a stalled consumer on one side does not block traffic to the other. Used in the CPU datapath to split a shared result/refill stream between two consumers, for example the register-file write port and the memory/CP0 path.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, ≥2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_sel  input  1  destination select: 0 = A, 1 = B.
- in_data  input  WIDTH  input word.
- in_ready  output  1  input word is accepted this cycle.
- a_valid  output  1  head of FIFO A is valid.
- a_data  output  WIDTH  head word of FIFO A.
- a_ready  input  1  consumer A takes the head word.
- a_count  output  CW  FIFO A occupancy, 0..DEPTH.
- b_valid  output  1  head of FIFO B is valid.
- b_data  output  WIDTH  head word of FIFO B.
- b_ready  input  1  consumer B takes the head word.
- b_count  output  CW  FIFO B occupancy, 0..DEPTH.

Behaviour:
- Reset (async, rst=1): all pointers, counts and storage go to 0, effective immediately and independent of clk. Resulting outputs: a_valid=b_valid=0, a_count=b_count=0, a_data=b_data=0. in_ready then follows the combinational rule below and is 1 while rst is held.
- Words in flight when reset asserts are discarded. No partial state survives reset.
- in_ready is combinational: in_ready = (in_sel ? b_count : a_count) != DEPTH.
- The producer holds in_sel and in_data stable while in_valid=1 and in_ready=0.
- Push: on a rising edge with in_valid & in_ready, in_data is written at the write pointer of the FIFO chosen by in_sel. That write pointer increments modulo DEPTH.
- At most one push per cycle, into exactly one FIFO. The other FIFO's write state is unchanged.
- Pop: on a rising edge with x_valid & x_ready (x = a or b), that FIFO's read pointer increments modulo DEPTH. A and B can pop in the same cycle, independently.
- x_valid = (x_count != 0). x_data is driven combinationally from storage at the read pointer.
- x_ready while x_valid=0 has no effect: no pointer move, no underflow.
- Latency: a word pushed at edge N is visible on x_valid/x_data after edge N, so it is poppable at edge N+1 at the earliest. There is no combinational in→out bypass.
- Count update per edge: x_count += push_x − pop_x. Simultaneous push and pop on the same non-empty, non-full FIFO leaves the count unchanged and both pointers advance.
- Full FIFO (count = DEPTH): in_ready is 0 for words selecting it, even when that FIFO pops in the same cycle. There is no push-through-when-full.
- Empty FIFO with a simultaneous push: the push succeeds; x_valid rises the next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked by the counter, never by pointer comparison.
- Ordering: FIFO order is preserved per output. No ordering guarantee exists between A and B.
- A full A does not stall words selecting B, and vice versa.
- Storage is not otherwise initialised. Data is never corrupted by a pop of an empty FIFO or a push to a full one, because both are blocked.

Test Plan:
1. Reset: assert rst mid-stream with a_count=2 → immediately a_valid=0, a_count=0, a_data=0. After release, in_ready=1 for both select values.
2. Routing/latency: push 0x11111111 (sel=0), then 0x22222222 (sel=1), with a_ready=b_ready=1 → a_data=0x11111111 valid one cycle after its push edge, B likewise. Counts return to 0.
3. Full/backpressure, DEPTH=2: a_ready=0; push 0xA0, 0xA1, 0xA2 to A → a_count=2 and in_ready=0 on the third word. Pushing 0xB0 to B (sel=1) is accepted in the same period with b_count=1.
4. Full plus simultaneous pop: A full, a_ready=1, in_valid=1 with sel=0 → this cycle in_ready=0, pop only, a_count=1. Next cycle the push is accepted; order 0xA0, 0xA1, 0xA2 is preserved at a_data.
5. Steady-state streaming and wrap: 16 consecutive sel=0 words 0..15 with a_ready=1 → one word per cycle after initial latency, a_count holds at 1, pointers wrap and order is intact.
6. Random regression: random in_valid, in_sel, a_ready, b_ready over 10k cycles, checked against per-output scoreboards → no loss, duplication or reorder; counts always in 0..DEPTH.
